// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates, measures line/frame length,
// tracks timing lock and grabs one probed pixel per frame.
//
//   state   | meaning
//   SEARCH  | waiting for a vertical sync edge to start measuring
//   MEASURE | counting consecutive error-free frames toward lock
//   LOCKED  | timing matches H_TOTAL/V_TOTAL; any error drops to SEARCH
module vga_rx_monitor #(
  parameter int   H_TOTAL     = 800,
  parameter int   V_TOTAL     = 525,
  parameter int   LOCK_FRAMES = 2,
  parameter logic SYNC_ACT    = 1'b0
) (
  input  logic        clk_50MHz,
  input  logic        clear,
  input  logic        pix_en,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        blank_n,
  input  logic [7:0]  red_in,
  input  logic [7:0]  green_in,
  input  logic [7:0]  blue_in,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [23:0] probe_rgb,
  output logic        probe_valid,
  output logic        frame_done
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0]   H_LEN  = 11'(H_TOTAL);
  localparam logic [10:0]   WD_LEN = 11'(2 * H_TOTAL);
  localparam logic [9:0]    V_LEN  = 10'(V_TOTAL);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);

  state_t        state_q;
  logic          h_prev_q, v_prev_q;
  logic [10:0]   h_cnt_q;
  logic [9:0]    v_cnt_q;
  logic [9:0]    x_pos_q, y_pos_q;
  logic [10:0]   line_len_q;
  logic [9:0]    frame_lines_q;
  logic          line_act_q, h_seen_q, frame_err_q, probe_done_q;
  logic [GW-1:0] good_cnt_q;
  logic [23:0]   probe_rgb_q;
  logic          locked_q, h_err_q, v_err_q, probe_valid_q, frame_done_q;

  logic          h_edge, v_edge, wd_hit, h_err_d, v_err_d, probe_hit;
  logic [10:0]   h_len;
  logic [9:0]    v_cnt_d;
  logic [GW-1:0] good_inc;

  assign h_edge   = pix_en && (h_prev_q != SYNC_ACT) && (h_sync == SYNC_ACT);
  assign v_edge   = pix_en && (v_prev_q != SYNC_ACT) && (v_sync == SYNC_ACT);
  assign h_len    = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 11'd1;
  assign wd_hit   = pix_en && !h_edge && (h_len == WD_LEN);
  assign h_err_d  = (h_edge && h_seen_q && (h_len != H_LEN)) || wd_hit;
  // The h edge of a same-sample h/v pair is counted into the frame it closes.
  assign v_cnt_d  = h_edge ? v_cnt_q + 10'd1 : v_cnt_q;
  assign v_err_d  = v_edge && (state_q != SEARCH) && (v_cnt_d != V_LEN);
  assign probe_hit = pix_en && blank_n && !probe_done_q &&
                     (x_pos_q == probe_x) && (y_pos_q == probe_y);
  assign good_inc = good_cnt_q + 1'b1;

  always_ff @(posedge clk_50MHz or negedge clear) begin
    if (!clear) begin
      state_q       <= SEARCH;
      h_prev_q      <= SYNC_ACT;
      v_prev_q      <= SYNC_ACT;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      line_act_q    <= 1'b0;
      h_seen_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      probe_done_q  <= 1'b0;
      good_cnt_q    <= '0;
      probe_rgb_q   <= '0;
      locked_q      <= 1'b0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      probe_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      frame_done_q  <= v_edge;
      probe_valid_q <= probe_hit;
      if (pix_en) begin
        h_prev_q <= h_sync;
        v_prev_q <= v_sync;
        v_cnt_q  <= v_cnt_d;
        if (h_edge) begin
          h_cnt_q    <= '0;
          line_len_q <= h_len;
          x_pos_q    <= '0;
          line_act_q <= 1'b0;
          h_seen_q   <= 1'b1;
          if (line_act_q) y_pos_q <= y_pos_q + 10'd1;
        end else begin
          h_cnt_q <= wd_hit ? 11'd0 : h_len;
          if (blank_n) begin
            x_pos_q    <= x_pos_q + 10'd1;
            line_act_q <= 1'b1;
          end
        end
        if (v_edge) begin
          frame_lines_q <= v_cnt_d;
          v_cnt_q       <= '0;
          y_pos_q       <= '0;
          probe_done_q  <= 1'b0;
        end
        if (probe_hit) begin
          probe_rgb_q  <= {red_in, green_in, blue_in};
          probe_done_q <= 1'b1;
        end
        case (state_q)
          SEARCH: if (v_edge) begin
            state_q     <= MEASURE;
            good_cnt_q  <= '0;
            frame_err_q <= 1'b0;
          end
          MEASURE: begin
            if (v_edge) begin
              frame_err_q <= 1'b0;
              if (frame_err_q || h_err_d || v_err_d) begin
                good_cnt_q <= '0;
              end else begin
                good_cnt_q <= good_inc;
                if (good_inc == LOCK_N) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end
            end else if (h_err_d || v_err_d) begin
              frame_err_q <= 1'b1;
            end
          end
          LOCKED: if (h_err_d || v_err_d) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
            h_seen_q <= 1'b0;
          end
          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign probe_rgb   = probe_rgb_q;
  assign probe_valid = probe_valid_q;
  assign frame_done  = frame_done_q;

endmodule
